// File: rtl/gpio_pad_ctrl_if.sv
// Signal bundle between the core, the pad cell and gpio_pad_ctrl.
// The master side is the core/pad environment; the slave side is the controller.
interface gpio_pad_ctrl_if;
  logic       CFG_WE;
  logic [7:0] CFG_WDATA;
  logic [7:0] CFG_RDATA;
  logic       DOUT;
  logic       DIN;
  logic       IRQ;
  logic       IRQ_CLR;
  logic       PAD_CS;
  logic       PAD_SL;
  logic       PAD_IE;
  logic       PAD_OE;
  logic       PAD_PU;
  logic       PAD_PD;
  logic       PAD_A;
  logic       PAD_PDRV0;
  logic       PAD_PDRV1;
  logic       PAD_Y;

  modport master (
    output CFG_WE, CFG_WDATA, DOUT, IRQ_CLR, PAD_Y,
    input  CFG_RDATA, DIN, IRQ,
    input  PAD_CS, PAD_SL, PAD_IE, PAD_OE, PAD_PU, PAD_PD, PAD_A, PAD_PDRV0, PAD_PDRV1
  );

  modport slave (
    input  CFG_WE, CFG_WDATA, DOUT, IRQ_CLR, PAD_Y,
    output CFG_RDATA, DIN, IRQ,
    output PAD_CS, PAD_SL, PAD_IE, PAD_OE, PAD_PU, PAD_PD, PAD_A, PAD_PDRV0, PAD_PDRV1
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Per-pad control/config register, input synchroniser, debounce filter and sticky edge IRQ.
// Define GPIO_PAD_CTRL_DEBOUNCE_EN to build the debounce filter; otherwise DIN is the synchroniser output.
module gpio_pad_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int IRQ_MODE  = 0
) (
  input logic           CLK,
  input logic           RN,
  gpio_pad_ctrl_if.slave bus
);

  logic [7:0] cfg_r;
  logic       a_r;
  logic       sync1_r;
  logic       sync2_r;
  logic       din_prev_r;
  logic       irq_r;
  logic       din_s;
  logic       edge_raw_s;
  logic       edge_s;
  logic       ie_s;

  assign ie_s = cfg_r[1];

  // Configuration register; a PU+PD request keeps only the pull-up.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cfg_r <= 8'h00;
    end else if (bus.CFG_WE) begin
      cfg_r <= {bus.CFG_WDATA[7:4], bus.CFG_WDATA[3] & ~bus.CFG_WDATA[2], bus.CFG_WDATA[2:0]};
    end
  end

  // Registered core output data toward the pad.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      a_r <= 1'b0;
    end else begin
      a_r <= bus.DOUT;
    end
  end

  // Two-flop synchroniser, held clear while the receiver is disabled.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else if (!ie_s) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.PAD_Y;
      sync2_r <= sync1_r;
    end
  end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             din_r;

  // Saturating increment so the counter can never wrap back into range.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
  end

  // Debounce filter: DIN follows sync only after DB_CYCLES consecutive disagreements.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_r <= {CNT_W{1'b0}};
      din_r <= 1'b0;
    end else if (!ie_s) begin
      cnt_r <= {CNT_W{1'b0}};
      din_r <= 1'b0;
    end else if (sync2_r == din_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s == CNT_W'(DB_CYCLES)) begin
      cnt_r <= {CNT_W{1'b0}};
      din_r <= sync2_r;
    end else begin
      cnt_r <= cnt_inc_s;
    end
  end

  assign din_s = din_r;
`else
  assign din_s = sync2_r;
`endif

  // Edge qualification against the configured polarity.
  always_comb begin
    edge_raw_s = 1'b0;
    case (IRQ_MODE)
      32'sd0:  edge_raw_s = din_s & ~din_prev_r;
      32'sd1:  edge_raw_s = ~din_s & din_prev_r;
      32'sd2:  edge_raw_s = din_s ^ din_prev_r;
      default: edge_raw_s = 1'b0;
    endcase
  end

  assign edge_s = edge_raw_s & ie_s;

  // Sticky IRQ; a new edge takes priority over a simultaneous clear.
  // The previous-DIN flop is cleared with IE so a forced DIN drop is never an edge.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      din_prev_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      din_prev_r <= ie_s ? din_s : 1'b0;
      if (edge_s) begin
        irq_r <= 1'b1;
      end else if (bus.IRQ_CLR) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end
    end
  end

  assign bus.CFG_RDATA = cfg_r;
  assign bus.DIN       = din_s;
  assign bus.IRQ       = irq_r;
  assign bus.PAD_OE    = cfg_r[0];
  assign bus.PAD_IE    = cfg_r[1];
  assign bus.PAD_PU    = cfg_r[2];
  assign bus.PAD_PD    = cfg_r[3];
  assign bus.PAD_CS    = cfg_r[4];
  assign bus.PAD_SL    = cfg_r[5];
  assign bus.PAD_PDRV0 = cfg_r[6];
  assign bus.PAD_PDRV1 = cfg_r[7];
  assign bus.PAD_A     = a_r;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: three instances (rising/falling/both IRQ modes) driven in parallel,
// checked against a cycle-level reference model plus directed latency and boundary checks.
module tb_gpio_pad_ctrl;
  localparam int DB = 4;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic       CLK;
  logic       RN;
  logic       cfg_we;
  logic [7:0] cfg_wdata;
  logic       dout;
  logic       irq_clr;
  logic       pad_y;

  logic [2:0] din_o;
  logic [2:0] irq_o;
  logic [7:0] rdata_o [3];
  logic [8:0] pads_o [3];

  int n_checks;
  int n_fail;

  bit [7:0] m_cfg;
  bit       m_a;
  bit       m_s1;
  bit       m_s2;
  bit       m_din;
  bit       m_prev;
  int       m_run;
  bit       m_irq [3];

  gpio_pad_ctrl_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gpio_pad_ctrl #(.DB_CYCLES(DB), .CNT_W(3), .IRQ_MODE(g)) u_dut (
      .CLK (CLK),
      .RN  (RN),
      .bus (bus[g])
    );
    assign bus[g].CFG_WE    = cfg_we;
    assign bus[g].CFG_WDATA = cfg_wdata;
    assign bus[g].DOUT      = dout;
    assign bus[g].IRQ_CLR   = irq_clr;
    assign bus[g].PAD_Y     = pad_y;
    assign din_o[g]   = bus[g].DIN;
    assign irq_o[g]   = bus[g].IRQ;
    assign rdata_o[g] = bus[g].CFG_RDATA;
    assign pads_o[g]  = {bus[g].PAD_CS, bus[g].PAD_SL, bus[g].PAD_IE, bus[g].PAD_OE, bus[g].PAD_PU,
                         bus[g].PAD_PD, bus[g].PAD_A, bus[g].PAD_PDRV0, bus[g].PAD_PDRV1};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cfg = 8'h00; m_a = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    m_din = 1'b0; m_prev = 1'b0; m_run = 0;
    for (int i = 0; i < 3; i++) m_irq[i] = 1'b0;
  endtask

  // One clock of the reference behaviour, using inputs as seen at the edge.
  task automatic model_step();
    bit ie, s2_old, din_old, up, down, hit;
    bit [7:0] w;
    ie = m_cfg[1];
    s2_old = m_s2;
    din_old = m_din;
    up = din_old && !m_prev;
    down = !din_old && m_prev;
    for (int i = 0; i < 3; i++) begin
      hit = ie && ((i == 0 && up) || (i == 1 && down) || (i == 2 && (up || down)));
      if (hit) m_irq[i] = 1'b1;
      else if (irq_clr) m_irq[i] = 1'b0;
    end
    m_prev = ie ? din_old : 1'b0;
    if (ie) begin
      m_s2 = m_s1;
      m_s1 = pad_y;
    end else begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    if (!ie) begin
      m_din = 1'b0;
      m_run = 0;
    end else if (s2_old == din_old) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DB) begin
        m_din = s2_old;
        m_run = 0;
      end
    end
`else
    m_din = m_s2;
`endif
    if (cfg_we) begin
      w = cfg_wdata;
      if (w[2] && w[3]) w[3] = 1'b0;
      m_cfg = w;
    end
    m_a = dout;
  endtask

  task automatic check_model();
    bit [8:0] exp_pads;
    exp_pads = {m_cfg[4], m_cfg[5], m_cfg[1], m_cfg[0], m_cfg[2], m_cfg[3], m_a, m_cfg[6], m_cfg[7]};
    for (int g = 0; g < 3; g++) begin
      check_val($sformatf("rdata%0d", g), rdata_o[g], m_cfg);
      check_val($sformatf("pads%0d", g), pads_o[g], exp_pads);
      check_val($sformatf("din%0d", g), din_o[g], m_din);
      check_val($sformatf("irq%0d", g), irq_o[g], m_irq[g]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_cfg(input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  initial begin
    int hold;
    n_checks = 0;
    n_fail = 0;
    RN = 1'b0;
    cfg_we = 1'b0; cfg_wdata = 8'h00; dout = 1'b0; irq_clr = 1'b0; pad_y = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_val("reset_rdata", rdata_o[0], 8'h00);
    check_val("reset_pads", pads_o[0], 9'h000);
    RN = 1'b1;
    tick();

    // PU/PD conflict and drive strength
    write_cfg(8'h0F);
    check_val("pupd_rdata", rdata_o[0], 8'h07);
    check_val("pupd_oe", bus[0].PAD_OE, 1'b1);
    check_val("pupd_ie", bus[0].PAD_IE, 1'b1);
    check_val("pupd_pu", bus[0].PAD_PU, 1'b1);
    check_val("pupd_pd", bus[0].PAD_PD, 1'b0);
    write_cfg(8'hC0);
    check_val("pdrv1", bus[0].PAD_PDRV1, 1'b1);
    check_val("pdrv0", bus[0].PAD_PDRV0, 1'b1);
    check_val("pdrv_oe", bus[0].PAD_OE, 1'b0);

    // Clean rising step: DIN after LAT cycles, IRQ one cycle later
    write_cfg(8'h02);
    ticks(3);
    pad_y = 1'b1;
    ticks(LAT - 1);
    check_val("step_din_early", din_o[0], 1'b0);
    tick();
    check_val("step_din", din_o[0], 1'b1);
    check_val("step_irq_early", irq_o[0], 1'b0);
    tick();
    check_val("step_irq", irq_o[0], 1'b1);
    check_val("step_irq_fall", irq_o[1], 1'b0);
    check_val("step_irq_both", irq_o[2], 1'b1);
    clear_irq();
    check_val("irq_clr", irq_o[0], 1'b0);

    // Three-cycle glitch
    pad_y = 1'b0;
    ticks(LAT + 3);
    clear_irq();
    pad_y = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) pad_y = 1'b0;
      tick();
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
      check_val("glitch_din", din_o[0], 1'b0);
`else
      check_val("glitch_din", din_o[0], (c >= 2 && c <= 4) ? 1'b1 : 1'b0);
`endif
    end
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    check_val("glitch_irq", irq_o[0], 1'b0);
`endif
    clear_irq();

    // Set wins over a simultaneous clear; both-edge mode catches the fall
    pad_y = 1'b1;
    ticks(LAT);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_val("setclr_irq", irq_o[0], 1'b1);
    clear_irq();
    pad_y = 1'b0;
    ticks(LAT + 1);
    check_val("fall_irq_both", irq_o[2], 1'b1);
    check_val("fall_irq_rise", irq_o[0], 1'b0);
    check_val("fall_irq_fall", irq_o[1], 1'b1);

    // Disabling the receiver drops DIN without an edge
    pad_y = 1'b1;
    ticks(LAT + 2);
    clear_irq();
    write_cfg(8'h00);
    check_val("iedrop_din_hold", din_o[1], 1'b1);
    tick();
    check_val("iedrop_din", din_o[1], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("iedrop_irq", irq_o[1], 1'b0);
    end

    // Randomised traffic
    write_cfg(8'h02);
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        pad_y = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      dout = 1'($urandom_range(0, 1));
      irq_clr = ($urandom_range(0, 7) == 0);
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_wdata = 8'($urandom);
      if ($urandom_range(0, 4) != 0) cfg_wdata[1] = 1'b1;
      tick();
    end
    cfg_we = 1'b0;
    irq_clr = 1'b0;

    // Asynchronous reset mid-traffic with everything enabled
    write_cfg(8'hFF);
    dout = 1'b1;
    ticks(LAT + 3);
    check_val("ff_rdata", rdata_o[0], 8'hF7);
    #2;
    RN = 1'b0;
    #1;
    model_reset();
    for (int g = 0; g < 3; g++) begin
      check_val("areset_rdata", rdata_o[g], 8'h00);
      check_val("areset_pads", pads_o[g], 9'h000);
      check_val("areset_din", din_o[g], 1'b0);
      check_val("areset_irq", irq_o[g], 1'b0);
    end
    @(negedge CLK);
    RN = 1'b1;
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
